// File: rtl/keycode_arbiter.sv
// Tracks held W/A/S/D keys from a 6-slot HID report and presents one movement
// keycode per frame. The most recent press wins, and the output changes only on a synchronized frame_clk edge.
module keycode_arbiter #(
  parameter logic [7:0] KEY_W = 8'h1A,
  parameter logic [7:0] KEY_A = 8'h04,
  parameter logic [7:0] KEY_S = 8'h16,
  parameter logic [7:0] KEY_D = 8'h07,
  parameter int         SLOTS = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [8*SLOTS-1:0] keycodes,
  output logic [7:0]         keycode,
  output logic               key_valid,
  output logic               press_strobe
);

  localparam logic [1:0] ID_W = 2'd0;
  localparam logic [1:0] ID_A = 2'd1;
  localparam logic [1:0] ID_S = 2'd2;
  localparam logic [1:0] ID_D = 2'd3;

  logic       r_sync1, r_sync2, r_sync3;
  logic [1:0] r_stk [4];
  logic [2:0] r_depth;
  logic [3:0] r_held_prev;

  logic       w_frame_tick;
  logic [3:0] w_held;
  logic       w_rollover;
  logic [3:0] w_rel, w_prs;
  logic [1:0] w_stk [4];
  logic [2:0] w_depth;
  logic       w_hit;
  logic [1:0] w_top_idx;
  logic [7:0] w_top_code;

  assign w_frame_tick = r_sync2 & ~r_sync3;

  always_comb begin
    w_held     = 4'b0000;
    w_rollover = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (keycodes[8*i +: 8] == 8'h01) w_rollover = 1'b1;
      if (keycodes[8*i +: 8] == KEY_W) w_held[ID_W] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_A) w_held[ID_A] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_S) w_held[ID_S] = 1'b1;
      if (keycodes[8*i +: 8] == KEY_D) w_held[ID_D] = 1'b1;
    end
  end

  // Releases are removed before presses are pushed. Pushing in order D, S, A, W leaves W on top.
  always_comb begin
    w_rel   = r_held_prev & ~w_held;
    w_prs   = w_held & ~r_held_prev;
    w_stk   = r_stk;
    w_depth = r_depth;
    w_hit   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_rel[k]) begin
        w_hit = 1'b0;
        for (int p = 0; p < 3; p++) begin
          if ((w_stk[p] == 2'(k)) && (3'(p) < w_depth)) w_hit = 1'b1;
          if (w_hit) w_stk[p] = w_stk[p+1];
        end
        if ((w_stk[3] == 2'(k)) && (w_depth == 3'd4)) w_hit = 1'b1;
        if (w_hit) w_depth = w_depth - 3'd1;
      end
    end
    for (int k = 3; k >= 0; k--) begin
      if (w_prs[k] && (w_depth < 3'd4)) begin
        w_stk[w_depth[1:0]] = 2'(k);
        w_depth             = w_depth + 3'd1;
      end
    end
  end

  assign w_top_idx = 2'(r_depth - 3'd1);

  always_comb begin
    w_top_code = 8'h00;
    if (r_depth != 3'd0) begin
      case (r_stk[w_top_idx])
        ID_W:    w_top_code = KEY_W;
        ID_A:    w_top_code = KEY_A;
        ID_S:    w_top_code = KEY_S;
        default: w_top_code = KEY_D;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_stk        <= '{default: 2'd0};
      r_depth      <= 3'd0;
      r_held_prev  <= 4'b0000;
      keycode      <= 8'h00;
      key_valid    <= 1'b0;
      press_strobe <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // A rollover report carries no trustworthy key state, so it is ignored entirely.
      if (!w_rollover) begin
        r_stk       <= w_stk;
        r_depth     <= w_depth;
        r_held_prev <= w_held;
      end
      if (w_frame_tick) begin
        keycode      <= w_top_code;
        key_valid    <= (w_top_code != 8'h00);
        press_strobe <= (w_top_code != 8'h00) && (w_top_code != keycode);
      end else begin
        press_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keycode_arbiter.sv
// Directed test-plan steps followed by random reports. The reference model keeps held keys as an ordered press list.
module tb_keycode_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [47:0] keycodes = '0;
  logic [7:0]  keycode;
  logic        key_valid;
  logic        press_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  keycode_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycodes(keycodes),
    .keycode(keycode), .key_valid(key_valid), .press_strobe(press_strobe)
  );

  always #10 Clk = ~Clk;

  // Key index: 0=W 1=A 2=S 3=D
  logic [7:0] code_of [4] = '{8'h1A, 8'h04, 8'h16, 8'h07};
  int         m_order[$];
  bit [3:0]   m_prev;
  bit         m_fc [3];
  logic [7:0] m_key;
  logic       m_strobe;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic fc, input logic [47:0] kc);
    bit [3:0]   held;
    bit         roll;
    bit         tick;
    logic [7:0] nk;
    logic [7:0] s;
    if (rst) begin
      m_order.delete();
      m_prev = '0;
      m_fc = '{0, 0, 0};
      m_key = 8'h00;
      m_strobe = 1'b0;
      return;
    end
    // The tick takes effect when frame_clk was high two edges ago and low three edges ago.
    tick = m_fc[1] && !m_fc[2];
    m_fc[2] = m_fc[1];
    m_fc[1] = m_fc[0];
    m_fc[0] = fc;
    if (tick) begin
      nk = (m_order.size() == 0) ? 8'h00 : code_of[m_order[$]];
      m_strobe = (nk != 8'h00) && (nk != m_key);
      m_key = nk;
    end else begin
      m_strobe = 1'b0;
    end
    held = '0;
    roll = 0;
    for (int i = 0; i < 6; i++) begin
      s = kc[8*i +: 8];
      if (s == 8'h01) roll = 1;
      for (int k = 0; k < 4; k++) if (s == code_of[k]) held[k] = 1;
    end
    if (!roll) begin
      for (int k = 0; k < 4; k++) begin
        if (m_prev[k] && !held[k]) begin
          for (int j = 0; j < m_order.size(); j++) begin
            if (m_order[j] == k) begin
              m_order.delete(j);
              break;
            end
          end
        end
      end
      for (int k = 3; k >= 0; k--) if (held[k] && !m_prev[k]) m_order.push_back(k);
      m_prev = held;
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge(Reset, frame_clk, keycodes);
    #1;
    chk("keycode", keycode, m_key);
    chk("key_valid", {7'd0, key_valid}, {7'd0, (m_key != 8'h00)});
    chk("press_strobe", {7'd0, press_strobe}, {7'd0, m_strobe});
    if (press_strobe === 1'b1) strobe_cnt++;
  endtask

  task automatic tick_frame();
    strobe_cnt = 0;
    frame_clk = 1'b1;
    repeat (4) cyc();
    frame_clk = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    int         gap;
    logic [7:0] pool [10];
    pool = '{8'h00, 8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h05, 8'h1A, 8'h07};

    // 1: reset state, then W press and strobe 3 Clk after the frame_clk rise
    Reset = 1'b1;
    repeat (2) cyc();
    chk("rst_keycode", keycode, 8'h00);
    chk("rst_valid", {7'd0, key_valid}, 8'h00);
    chk("rst_strobe", {7'd0, press_strobe}, 8'h00);
    Reset = 1'b0;
    keycodes = {40'h0, 8'h1A};
    repeat (2) cyc();
    frame_clk = 1'b1;
    cyc();
    cyc();
    chk("t1_strobe_early", {7'd0, press_strobe}, 8'h00);
    cyc();
    chk("t1_keycode", keycode, 8'h1A);
    chk("t1_valid", {7'd0, key_valid}, 8'h01);
    chk("t1_strobe", {7'd0, press_strobe}, 8'h01);
    cyc();
    chk("t1_strobe_width", {7'd0, press_strobe}, 8'h00);
    frame_clk = 1'b0;
    repeat (4) cyc();

    // 2: A held, D added, then D released so the output falls back to A
    keycodes = {40'h0, 8'h04};
    repeat (2) cyc();
    keycodes = {32'h0, 8'h07, 8'h04};
    repeat (2) cyc();
    tick_frame();
    chk("t2_d", keycode, 8'h07);
    chk("t2_d_strobes", 8'(strobe_cnt), 8'd1);
    keycodes = {40'h0, 8'h04};
    cyc();
    tick_frame();
    chk("t2_fallback_a", keycode, 8'h04);
    chk("t2_a_strobes", 8'(strobe_cnt), 8'd1);

    // 3: four keys pressed together; the priority order decides what ends on top
    keycodes = '0;
    cyc();
    keycodes = {16'h0, 8'h04, 8'h16, 8'h1A, 8'h07};
    cyc();
    tick_frame();
    chk("t3_all_w", keycode, 8'h1A);
    keycodes = {16'h0, 8'h04, 8'h16, 8'h00, 8'h07};
    cyc();
    tick_frame();
    chk("t3_rel_w", keycode, 8'h04);
    keycodes = {16'h0, 8'h00, 8'h16, 8'h00, 8'h07};
    cyc();
    tick_frame();
    chk("t3_rel_a", keycode, 8'h16);

    // 4: a rollover report with W absent must not release W
    keycodes = {40'h0, 8'h1A};
    cyc();
    tick_frame();
    chk("t4_w", keycode, 8'h1A);
    keycodes = {40'h0, 8'h01};
    repeat (3) cyc();
    tick_frame();
    chk("t4_rollover_hold", keycode, 8'h1A);
    chk("t4_no_strobe", 8'(strobe_cnt), 8'd0);
    keycodes = {40'h0, 8'h1A};
    cyc();
    tick_frame();
    chk("t4_still_w", keycode, 8'h1A);

    // 5: a press and release within one frame are invisible; non-movement codes are ignored
    keycodes = '0;
    cyc();
    tick_frame();
    chk("t5_none", keycode, 8'h00);
    keycodes = {40'h0, 8'h1A};
    repeat (3) cyc();
    keycodes = '0;
    cyc();
    tick_frame();
    chk("t5_blip", keycode, 8'h00);
    chk("t5_blip_strobe", 8'(strobe_cnt), 8'd0);
    keycodes = {40'h0, 8'h2C};
    cyc();
    tick_frame();
    chk("t5_2c", keycode, 8'h00);

    // 6: reset while keys are held and frame_clk is high
    keycodes = {40'h0, 8'h04};
    cyc();
    keycodes = {32'h0, 8'h16, 8'h04};
    cyc();
    frame_clk = 1'b1;
    repeat (4) cyc();
    chk("t6_pre_s", keycode, 8'h16);
    Reset = 1'b1;
    cyc();
    chk("t6_reset", keycode, 8'h00);
    Reset = 1'b0;
    cyc();
    cyc();
    chk("t6_wait", keycode, 8'h00);
    cyc();
    chk("t6_prio_a", keycode, 8'h04);
    chk("t6_strobe", {7'd0, press_strobe}, 8'h01);
    frame_clk = 1'b0;
    repeat (4) cyc();

    // Random reports, frame periods, rollovers and occasional resets
    gap = 10;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 6; i++) keycodes[8*i +: 8] = pool[$urandom_range(0, 9)];
        if ($urandom_range(0, 29) == 0) keycodes[8*$urandom_range(0, 5) +: 8] = 8'h01;
      end
      gap--;
      if (gap <= 0) begin
        frame_clk = ~frame_clk;
        gap = $urandom_range(2, 40);
      end
      Reset = ($urandom_range(0, 599) == 0);
      cyc();
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
